calc_cmd_scheduler: RTL and testbench

Queues decoded button commands for the stack calculator and issues them one at a time to the stack controller over a valid/ready/done handshake. It sits between the button decoder (one-cycle command pulses) and the controller's instruction input. Commands pressed while the controller is mid-operation (ADD/SUB multi-pass, CLEAR sweep) are buffered rather than lost. It also provides CLEAR priority, a drop counter and a completion watchdog.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_cmd_scheduler_if.sv | 31 +++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/calc_cmd_scheduler.sv | 131 +++++++++++++
 tb/tb_calc_cmd_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the stack calculator: opcodes, legality check,
// and the command scheduler state encoding.
package calc_pkg;

  typedef logic [3:0] op_t;

  // Opcodes match the stack controller's state encoding; 0 is STANDBY.
  localparam op_t OP_STANDBY = 4'd0;
  localparam op_t OP_PUSH    = 4'd1;
  localparam op_t OP_POP     = 4'd2;
  localparam op_t OP_ADD     = 4'd5;
  localparam op_t OP_SUB     = 4'd6;
  localparam op_t OP_TOP     = 4'd9;
  localparam op_t OP_CLEAR   = 4'd10;
  localparam op_t OP_INC     = 4'd13;
  localparam op_t OP_DEC     = 4'd14;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT} sched_state_t;

  function automatic logic is_legal_op(input op_t op);
    case (op)
      OP_PUSH, OP_POP, OP_ADD, OP_SUB,
      OP_TOP, OP_CLEAR, OP_INC, OP_DEC: is_legal_op = 1'b1;
      default:                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_cmd_scheduler_if.sv
// Command-in / issue-out bundle between button decoder, scheduler and
// stack controller. slave = scheduler side, master = environment side.
interface calc_cmd_scheduler_if
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  op_t           cmd_code;
  logic          issue_valid;
  op_t           issue_code;
  logic          issue_ready;
  logic          issue_done;
  logic          busy;
  logic [CW-1:0] q_count;
  logic [7:0]    drop_cnt;
  logic          timeout_flag;

  modport slave (
    input  cmd_valid, cmd_code, issue_ready, issue_done,
    output issue_valid, issue_code, busy, q_count, drop_cnt, timeout_flag
  );

  modport master (
    output cmd_valid, cmd_code, issue_ready, issue_done,
    input  issue_valid, issue_code, busy, q_count, drop_cnt, timeout_flag
  );

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with flush. A flush in the same cycle as a push
// leaves exactly the pushed entry in the queue.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A full FIFO still takes a push when the head leaves the same cycle.
  assign do_push = push_i && (flush_i || !full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Storage; a flushing push restarts the queue at slot 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[flush_i ? '0 : wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= do_push ? AW'(1) : '0;
      count_q  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Buffers decoded button commands and issues them one at a time to the
// stack controller, with CLEAR priority, a drop counter and a watchdog.
module calc_cmd_scheduler
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  calc_cmd_scheduler_if.slave  bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  sched_state_t   state_q, state_d;
  logic           valid_q, valid_d;
  op_t            code_q, code_d;
  logic           busy_q, busy_d;
  logic           to_q, to_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [7:0]     drop_q, drop_d;

  logic           is_clear, hs, fifo_push, drop_evt;
  op_t            fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full, fifo_empty;

  // CLEAR flushes and re-seeds the queue. A handshake in the same cycle
  // still completes: the accepted command is in flight and is not aborted.
  assign is_clear  = bus.cmd_valid && (bus.cmd_code == OP_CLEAR);
  assign hs        = (state_q == OFFER) && bus.issue_ready;
  assign fifo_push = bus.cmd_valid && is_legal_op(bus.cmd_code) &&
                     (is_clear || !fifo_full || hs);
  assign drop_evt  = bus.cmd_valid && !fifo_push;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (hs),
    .flush_i (is_clear),
    .din_i   (bus.cmd_code),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturating drop counter.
  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Issue FSM: next state, offer register, busy and watchdog.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    busy_d  = busy_q;
    wd_d    = wd_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        // Skip loading on a flush cycle so a stale head is never offered.
        if (!fifo_empty && !is_clear) begin
          valid_d = 1'b1;
          code_d  = fifo_dout;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          valid_d = 1'b0;
          code_d  = OP_STANDBY;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = WAIT;
        end else if (is_clear) begin
          valid_d = 1'b0;
          code_d  = OP_STANDBY;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.issue_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= OP_STANDBY;
      busy_q  <= 1'b0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.issue_valid  = valid_q;
  assign bus.issue_code   = code_q;
  assign bus.busy         = busy_q;
  assign bus.q_count      = fifo_count;
  assign bus.drop_cnt     = drop_q;
  assign bus.timeout_flag = to_q;

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed bench for calc_cmd_scheduler: a cycle-by-cycle vector table plus
// hand sequences for saturation, watchdog, full push+pop and reset.
module tb_calc_cmd_scheduler;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_cmd_scheduler_if #(.DEPTH(4)) bus();

  calc_cmd_scheduler #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [3:0] cd;
    logic       rdy;
    logic       dn;
    logic       e_valid;
    logic [3:0] e_code;
    logic       e_busy;
    int         e_cnt;
    int         e_drop;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic rst, input logic cv, input int cd,
                              input logic rdy, input logic dn,
                              input logic ev, input int ec, input logic eb,
                              input int en, input int ed);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cd = 4'(cd); v.rdy = rdy; v.dn = dn;
    v.e_valid = ev; v.e_code = 4'(ec); v.e_busy = eb; v.e_cnt = en; v.e_drop = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input int cd, input logic rdy, input logic dn);
    bus.cmd_valid   = cv;
    bus.cmd_code    = 4'(cd);
    bus.issue_ready = rdy;
    bus.issue_done  = dn;
  endtask

  task automatic check_out(input string tag, input logic ev, input int ec,
                           input logic eb, input int en, input int ed);
    check({tag, " issue_valid"}, 32'(bus.issue_valid), 32'(ev));
    check({tag, " issue_code"},  32'(bus.issue_code),  32'(ec));
    check({tag, " busy"},        32'(bus.busy),        32'(eb));
    check({tag, " q_count"},     32'(bus.q_count),     32'(en));
    check({tag, " drop_cnt"},    32'(bus.drop_cnt),    32'(ed));
  endtask

  initial begin
    int exp_order [4];
    exp_order = '{2, 5, 6, 9};

    //             rst cv cd rdy dn | valid code busy cnt drop
    tbl[0]  = mk(0, 1,  1, 1, 0,  0,  0, 0, 1, 0); // PUSH
    tbl[1]  = mk(0, 0,  0, 1, 0,  1,  1, 0, 1, 0); // offered at cycle 2
    tbl[2]  = mk(0, 0,  0, 1, 0,  0,  0, 1, 0, 0); // handshake -> busy
    tbl[3]  = mk(0, 0,  0, 1, 0,  0,  0, 1, 0, 0);
    tbl[4]  = mk(0, 0,  0, 1, 0,  0,  0, 1, 0, 0);
    tbl[5]  = mk(0, 0,  0, 1, 1,  0,  0, 0, 0, 0); // done at 5 -> idle at 6
    tbl[6]  = mk(0, 0,  0, 1, 1,  0,  0, 0, 0, 0); // stray done ignored
    tbl[7]  = mk(0, 1,  5, 0, 0,  0,  0, 0, 1, 0); // ADD
    tbl[8]  = mk(0, 1,  6, 0, 0,  1,  5, 0, 2, 0); // SUB
    tbl[9]  = mk(0, 1,  9, 0, 0,  1,  5, 0, 3, 0); // TOP
    tbl[10] = mk(0, 1, 13, 0, 0,  1,  5, 0, 4, 0); // INC -> full
    tbl[11] = mk(0, 1, 14, 0, 0,  1,  5, 0, 4, 1); // DEC dropped
    tbl[12] = mk(0, 0,  0, 0, 0,  1,  5, 0, 4, 1); // offer held
    tbl[13] = mk(0, 1, 10, 0, 0,  0,  0, 0, 1, 1); // CLEAR withdraws offer
    tbl[14] = mk(0, 0,  0, 0, 0,  1, 10, 0, 1, 1); // CLEAR offered
    tbl[15] = mk(1, 0,  0, 0, 0,  0,  0, 0, 0, 0); // reset
    tbl[16] = mk(0, 1,  3, 0, 0,  0,  0, 0, 0, 1); // illegal 3
    tbl[17] = mk(0, 1,  0, 0, 0,  0,  0, 0, 0, 2); // illegal 0
    tbl[18] = mk(0, 0,  3, 0, 0,  0,  0, 0, 0, 2); // code without valid

    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset timeout_flag", 32'(bus.timeout_flag), 32'd0);

    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].cv, int'(tbl[i].cd), tbl[i].rdy, tbl[i].dn);
      tick();
      check_out($sformatf("row%0d", i), tbl[i].e_valid, int'(tbl[i].e_code),
                tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_drop);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1, 15, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    check("sat drop_cnt", 32'(bus.drop_cnt), 32'd255);
    check("sat q_count", 32'(bus.q_count), 32'd0);

    // Full queue: push and handshake in the same cycle, then drain in order.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 1, 0, 0); tick();
    drive(1, 2, 0, 0); tick();
    drive(1, 5, 0, 0); tick();
    drive(1, 6, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    check_out("full", 1, 1, 0, 4, 0);
    drive(1, 9, 1, 0); tick();
    check_out("full push+pop", 0, 0, 1, 4, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1); tick();
      check($sformatf("drain%0d busy after done", i), 32'(bus.busy), 32'd0);
      drive(0, 0, 0, 0); tick();
      check($sformatf("drain%0d valid", i), 32'(bus.issue_valid), 32'd1);
      check($sformatf("drain%0d code", i), 32'(bus.issue_code), 32'(exp_order[i]));
      drive(0, 0, 1, 0); tick();
      check($sformatf("drain%0d busy", i), 32'(bus.busy), 32'd1);
      check($sformatf("drain%0d q_count", i), 32'(bus.q_count), 32'(3 - i));
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);

    // Watchdog: POP issued, issue_done never arrives; TOP waits behind it.
    drive(1, 2, 1, 0); tick();
    drive(1, 9, 1, 0); tick();
    check_out("wd offer", 1, 2, 0, 2, 0);
    drive(0, 0, 1, 0); tick();
    check_out("wd wait", 0, 0, 1, 1, 0);
    for (int i = 0; i < 254; i++) tick();
    check("wd flag early", 32'(bus.timeout_flag), 32'd0);
    check("wd busy early", 32'(bus.busy), 32'd1);
    drive(0, 0, 0, 0); tick();
    check("wd flag set", 32'(bus.timeout_flag), 32'd1);
    check("wd busy cleared", 32'(bus.busy), 32'd0);
    tick();
    check_out("wd next issue", 1, 9, 0, 1, 0);
    drive(0, 0, 1, 0); tick();
    check("wd next busy", 32'(bus.busy), 32'd1);
    drive(0, 0, 0, 1); tick();
    check("wd flag sticky", 32'(bus.timeout_flag), 32'd1);

    // Reset while a command is in flight with a non-empty queue.
    drive(1, 13, 1, 0); tick();
    drive(1, 3, 1, 0);  tick();
    drive(1, 14, 1, 0); tick();
    check_out("pre-reset", 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("mid reset", 0, 0, 0, 0, 0);
    check("mid reset timeout_flag", 32'(bus.timeout_flag), 32'd0);
    tick();
    check("post reset valid", 32'(bus.issue_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
